// File: rtl/serial_shift_sched.sv
// Round-robin scheduler sharing one serial shift-and-count datapath between two
// word requesters: grants a word, shifts it LSB-first, tallies ones, pulses done.
module serial_shift_sched #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_en,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] ones_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_ones;
  logic             r_cur_id;
  logic             r_done_id;
  logic             r_last_grant;

  logic             w_idle;
  logic             w_shift;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [WIDTH-1:0] w_load_data;
  logic             w_bit_last;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_idx_next;

  // The ones tally never wraps because 2**CNT_W > WIDTH.
  function automatic logic [CNT_W-1:0] tally_add(input logic [CNT_W-1:0] acc,
                                                 input logic bit_in);
    return acc + {{(CNT_W-1){1'b0}}, bit_in};
  endfunction

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_shift     = (r_state == ST_SHIFT);
  assign w_grant0    = w_idle & req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1    = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept    = w_grant0 | w_grant1;
  assign w_load_data = w_grant1 ? req1_data : req0_data;

  assign w_bit_last  = (r_idx == LAST_IDX);
  assign w_acc_next  = tally_add(r_acc, r_shreg[0]);
  assign w_idx_next  = r_idx + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_ones       <= '0;
      r_cur_id     <= 1'b0;
      r_done_id    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg      <= w_load_data;
            r_idx        <= '0;
            r_acc        <= '0;
            r_cur_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg >> 1;
          r_idx   <= w_idx_next;
          if (w_bit_last) begin
            r_ones    <= w_acc_next;
            r_done_id <= r_cur_id;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign ser_en     = w_shift;
  assign ser_bit    = w_shift & r_shreg[0];
  assign ser_first  = w_shift & (r_idx == '0);
  assign ser_last   = w_shift & w_bit_last;
  assign busy       = w_shift | (r_state == ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign done_id    = r_done_id;
  assign ones_count = r_ones;

endmodule

// File: tb/tb_serial_shift_sched.sv
// Self-checking bench for serial_shift_sched: per-cycle reference model with a
// scoreboard of accepted words, a vector table, and hand-written corner sequences.
module tb_serial_shift_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [15:0] d0, d1;
  logic        req0_ready, req1_ready, ser_en, ser_bit, ser_first, ser_last;
  logic        busy, done, done_id;
  logic [4:0]  ones_count;

  logic        s_v0, s_v1;
  logic [3:0]  s_d0, s_d1;
  logic        s_rdy0, s_rdy1, s_en, s_bit, s_first, s_last, s_busy, s_done, s_id;
  logic [2:0]  s_ones;

  always #5 clk = ~clk;

  serial_shift_sched #(.WIDTH(16), .CNT_W(5)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .ser_en(ser_en), .ser_bit(ser_bit), .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .done(done), .done_id(done_id), .ones_count(ones_count)
  );

  serial_shift_sched #(.WIDTH(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(s_v0), .req0_data(s_d0), .req0_ready(s_rdy0),
    .req1_valid(s_v1), .req1_data(s_d1), .req1_ready(s_rdy1),
    .ser_en(s_en), .ser_bit(s_bit), .ser_first(s_first), .ser_last(s_last),
    .busy(s_busy), .done(s_done), .done_id(s_id), .ones_count(s_ones)
  );

  typedef struct { logic id; logic [15:0] word; } exp_t;
  typedef struct { logic v0; logic [15:0] d0; logic v1; logic [15:0] d1;
                   logic id; logic [4:0] ones; } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   lo, hi;
  logic last;
  logic [4:0] held_ones;
  logic held_id;
  exp_t exp_q[$];
  int   log_cyc[$];
  logic log_id[$];
  logic acc_flag, acc_id, done_flag, done_id_seen;
  logic [4:0] done_ones_seen;
  vec_t tab[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [4:0] popcnt(input logic [15:0] w);
    logic [4:0] n = 0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, w[i]};
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last = 1'b1; lo = 1; hi = 0;
    held_ones = 0; held_id = 0;
  endtask

  // Compare every output of the 16-bit instance for the current cycle.
  task automatic check_cycle();
    logic busy_e, done_e, shift_e, r0_e, r1_e;
    int k;
    exp_t cur;
    if (reset) return;
    busy_e  = (cyc >= lo) && (cyc <= hi);
    done_e  = busy_e && (cyc == hi);
    shift_e = busy_e && !done_e;
    r0_e = !busy_e && v0 && (!v1 || last);
    r1_e = !busy_e && v1 && (!v0 || !last);
    chk("req0_ready", req0_ready, r0_e);
    chk("req1_ready", req1_ready, r1_e);
    chk("busy", busy, busy_e);
    chk("done", done, done_e);
    chk("ser_en", ser_en, shift_e);
    if (shift_e) begin
      k = cyc - lo;
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        chk("ser_bit", ser_bit, cur.word[k]);
        chk("ser_first", ser_first, k == 0);
        chk("ser_last", ser_last, k == 15);
      end
    end else begin
      chk("ser_bit_idle", ser_bit, 1'b0);
      chk("ser_first_idle", ser_first, 1'b0);
      chk("ser_last_idle", ser_last, 1'b0);
    end
    if (done_e && exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      held_ones = popcnt(cur.word);
      held_id = cur.id;
    end
    chk("ones_count", ones_count, held_ones);
    chk("done_id", done_id, held_id);
    if (done) begin
      done_flag = 1; done_ones_seen = ones_count; done_id_seen = done_id;
    end
    if (r0_e || r1_e) begin
      exp_q.push_back('{id: r1_e, word: r1_e ? d1 : d0});
      last = r1_e; lo = cyc + 1; hi = cyc + 17;
      acc_flag = 1; acc_id = r1_e;
      log_cyc.push_back(cyc + 1); log_id.push_back(r1_e);
    end
  endtask

  task automatic tick();
    #1 check_cycle();
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    s_v0 = 0; s_v1 = 0; s_d0 = 0; s_d1 = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_ser_en", ser_en, 0); chk("rst_done", done, 0);
    chk("rst_ones", ones_count, 0); chk("rst_id", done_id, 0);
    chk("rst_rdy0", req0_ready, 0); chk("rst_rdy1", req1_ready, 0);
    model_reset();
    reset = 0;
  endtask

  task automatic wait_accept(input string name);
    acc_flag = 0;
    for (int t = 0; t < 40 && !acc_flag; t++) tick();
    chk({name, "_accept"}, acc_flag, 1);
  endtask

  task automatic wait_done(input string name);
    done_flag = 0;
    for (int t = 0; t < 40 && !done_flag; t++) tick();
    chk({name, "_done"}, done_flag, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{1, 16'hF0A4, 0, 16'h0000, 0, 5'd7};
    tab[1] = '{0, 16'h0000, 1, 16'h8001, 1, 5'd2};
    tab[2] = '{1, 16'hFFFF, 1, 16'h0000, 0, 5'd16};
    tab[3] = '{1, 16'h1234, 1, 16'h00FF, 1, 5'd8};
    tab[4] = '{1, 16'h0000, 0, 16'h0000, 0, 5'd0};
    tab[5] = '{1, 16'hAAAA, 1, 16'h5555, 1, 5'd8};
    tab[6] = '{0, 16'h0000, 1, 16'hFFFE, 1, 5'd15};

    model_reset();
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 7; i++) begin
      v0 = tab[i].v0; d0 = tab[i].d0; v1 = tab[i].v1; d1 = tab[i].d1;
      wait_accept("tab");
      chk("tab_grant", acc_id, tab[i].id);
      v0 = 0; v1 = 0; d0 = ~d0; d1 = ~d1;
      wait_done("tab");
      chk("tab_ones", done_ones_seen, tab[i].ones);
      chk("tab_done_id", done_id_seen, tab[i].id);
      repeat (3) tick();
    end

    // Continuous contention: grants must alternate, 18 cycles apart.
    apply_reset();
    log_cyc.delete(); log_id.delete();
    v0 = 1; d0 = 16'hFFFF; v1 = 1; d1 = 16'h0000;
    repeat (78) tick();
    v0 = 0; v1 = 0;
    repeat (20) tick();
    chk("alt_count", log_id.size() >= 4, 1);
    if (log_id.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("alt_id", log_id[i], i % 2);
        if (i > 0) chk("alt_spacing", log_cyc[i] - log_cyc[i-1], 18);
      end

    // req1 arrives mid-shift and waits; data changes after accept are ignored.
    log_cyc.delete(); log_id.delete();
    v0 = 1; d0 = 16'h1111;
    wait_accept("mid0");
    v0 = 0; d0 = 16'hFFFF; v1 = 1; d1 = 16'hC3C3;
    wait_accept("mid1");
    chk("mid1_id", acc_id, 1);
    if (log_cyc.size() >= 2) chk("mid1_wait", log_cyc[1] - log_cyc[0], 18);
    v1 = 0; d1 = 16'h0000;
    wait_done("mid1");
    chk("mid1_ones", done_ones_seen, 8);
    repeat (2) tick();

    // Asynchronous reset at bit 5 of 16'hAAAA.
    v0 = 1; d0 = 16'hAAAA;
    wait_accept("ar");
    v0 = 0;
    for (int t = 0; t < 20 && cyc < lo + 5; t++) tick();
    #1 chk("ar_pre_bit", ser_en, 1);
    reset = 1;
    #1;
    chk("ar_ser_en", ser_en, 0); chk("ar_ser_bit", ser_bit, 0);
    chk("ar_first", ser_first, 0); chk("ar_last", ser_last, 0);
    chk("ar_busy", busy, 0); chk("ar_done", done, 0);
    chk("ar_ones", ones_count, 0); chk("ar_id", done_id, 0);
    @(posedge clk); cyc++;
    @(negedge clk);
    model_reset();
    reset = 0;
    v0 = 1; d0 = 16'h0F0F; v1 = 1; d1 = 16'hF0F0;
    wait_accept("ar_tie");
    chk("ar_tie_id", acc_id, 0);
    v0 = 0; v1 = 0;
    wait_done("ar_tie");
    chk("ar_tie_ones", done_ones_seen, 8);
    repeat (4) tick();

    // WIDTH=4 instance: 4'hF gives four ones and done four cycles after the first bit.
    s_v0 = 1; s_d0 = 4'hF;
    #1 chk("w4_ready", s_rdy0, 1);
    tick();
    s_v0 = 0; s_d0 = 4'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("w4_en", s_en, 1); chk("w4_bit", s_bit, 1);
      chk("w4_first", s_first, k == 0); chk("w4_last", s_last, k == 3);
      chk("w4_done_early", s_done, 0);
      tick();
    end
    #1;
    chk("w4_done", s_done, 1); chk("w4_ones", s_ones, 3'd4); chk("w4_id", s_id, 0);
    chk("w4_done_en", s_en, 0);
    tick();
    #1;
    chk("w4_done_pulse", s_done, 0); chk("w4_busy", s_busy, 0); chk("w4_hold", s_ones, 3'd4);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
